sdram_rd_arbiter: RTL and testbench

// Upstream SDRAM read-port arbiter that feeds the I2S audio streamer and the video frame reader.
// - Muxes two word-read requesters onto the single SDRAM controller read port.
// - Grants a requester a lock for a whole burst.
// - Returns each 128-bit word with a one-cycle ack and holds the data stable until the next ack.
// - Audio has priority so the I2S FIFO never underruns.

---
 rtl/sdram_rd_arbiter.sv | 92 +++++++++
 tb/tb_sdram_rd_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_arbiter.sv
// sdram_rd_arbiter: burst-locked two-requester SDRAM read arbiter, audio has priority, one read outstanding
module sdram_rd_arbiter #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 128,
  parameter int GAP_MAX  = 4,
  parameter int MAX_LOCK = 256
) (
  input  logic              Clk50,
  input  logic              reset,
  input  logic              a_rd,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ac,
  output logic [DATA_W-1:0] a_data,
  output logic              a_wait,
  input  logic              v_rd,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_ac,
  output logic [DATA_W-1:0] v_data,
  output logic              v_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_err
);
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic [2:0] {IDLE, OWN, REQ, WAIT, ACK} state_t;
  state_t state, state_n;
  logic owner, owner_n;
  logic [GW-1:0] gap, gap_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic own_rd, oth_rd;
  assign own_rd  = owner ? v_rd : a_rd;
  assign oth_rd  = owner ? a_rd : v_rd;
  assign cnt_inc = (cnt == CW'(MAX_LOCK)) ? cnt : cnt + CW'(1);
  assign mem_req = state == REQ;
  assign a_ac    = state == ACK && !owner;
  assign v_ac    = state == ACK && owner;
  always_comb begin
    state_n = state;
    owner_n = owner;
    gap_n   = gap;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        gap_n = '0;
        cnt_n = '0;
        owner_n = (a_rd || v_rd) ? !a_rd : owner;
        state_n = (a_rd || v_rd) ? REQ : IDLE;
      end
      OWN: begin
        gap_n   = own_rd ? '0 : gap + GW'(1);
        state_n = own_rd ? REQ : (gap == GW'(GAP_MAX - 1)) ? IDLE : OWN;
      end
      REQ:  state_n = mem_gnt ? WAIT : REQ;
      WAIT: state_n = mem_rvalid ? ACK : WAIT;
      ACK: begin
        gap_n   = '0;
        cnt_n   = cnt_inc;
        state_n = (cnt_inc == CW'(MAX_LOCK) && oth_rd) ? IDLE : OWN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      gap      <= '0;
      cnt      <= '0;
      mem_addr <= '0;
      a_data   <= '0;
      v_data   <= '0;
      a_wait   <= 1'b0;
      v_wait   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      gap    <= gap_n;
      cnt    <= cnt_n;
      a_wait <= state_n != IDLE && owner_n;
      v_wait <= state_n != IDLE && !owner_n;
      rd_err <= rd_err || (mem_rvalid && state != WAIT);
      if (state_n == REQ && state != REQ) mem_addr <= owner_n ? v_addr : a_addr;
      if (state == WAIT && mem_rvalid && !owner) a_data <= mem_rdata;
      if (state == WAIT && mem_rvalid && owner) v_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// tb_sdram_rd_arbiter: directed scoreboard bench for sdram_rd_arbiter (default build plus a MAX_LOCK=4 build)
module tb_sdram_rd_arbiter;
  localparam logic [127:0] JUNK = {4{32'hDEADBEEF}};
  typedef struct packed {logic v; logic [21:0] addr;} exp_t;
  logic Clk50 = 1'b0, reset = 1'b1, a_rd = 1'b0, v_rd = 1'b0, spur = 1'b0, sel = 1'b0;
  logic mem_gnt, mem_rvalid;
  logic [21:0] a_addr = '0, v_addr = '0, ra;
  logic [127:0] mem_rdata, exp_a = '0, exp_v = '0;
  logic a_ac_i[2], v_ac_i[2], a_wait_i[2], v_wait_i[2], mem_req_i[2], rd_err_i[2];
  logic [127:0] a_data_i[2], v_data_i[2];
  logic [21:0] mem_addr_i[2];
  logic a_ac, v_ac, a_wait, v_wait, mem_req, rd_err;
  logic [127:0] a_data, v_data;
  logic [21:0] mem_addr;
  int gnt_dly = 1, rv_dly = 1, n_cmp = 0, n_err = 0, n;
  exp_t exp_q[$];

  assign a_ac = a_ac_i[sel];
  assign v_ac = v_ac_i[sel];
  assign a_wait = a_wait_i[sel];
  assign v_wait = v_wait_i[sel];
  assign mem_req = mem_req_i[sel];
  assign rd_err = rd_err_i[sel];
  assign a_data = a_data_i[sel];
  assign v_data = v_data_i[sel];
  assign mem_addr = mem_addr_i[sel];

  sdram_rd_arbiter u_dut (
    .Clk50(Clk50), .reset(reset),
    .a_rd(a_rd), .a_addr(a_addr), .a_ac(a_ac_i[0]), .a_data(a_data_i[0]), .a_wait(a_wait_i[0]),
    .v_rd(v_rd), .v_addr(v_addr), .v_ac(v_ac_i[0]), .v_data(v_data_i[0]), .v_wait(v_wait_i[0]),
    .mem_req(mem_req_i[0]), .mem_addr(mem_addr_i[0]), .mem_gnt(mem_gnt && !sel),
    .mem_rvalid((mem_rvalid || spur) && !sel), .mem_rdata(spur ? JUNK : mem_rdata), .rd_err(rd_err_i[0])
  );

  sdram_rd_arbiter #(.MAX_LOCK(4)) u_dut_ml4 (
    .Clk50(Clk50), .reset(reset),
    .a_rd(a_rd), .a_addr(a_addr), .a_ac(a_ac_i[1]), .a_data(a_data_i[1]), .a_wait(a_wait_i[1]),
    .v_rd(v_rd), .v_addr(v_addr), .v_ac(v_ac_i[1]), .v_data(v_data_i[1]), .v_wait(v_wait_i[1]),
    .mem_req(mem_req_i[1]), .mem_addr(mem_addr_i[1]), .mem_gnt(mem_gnt && sel),
    .mem_rvalid(mem_rvalid && sel), .mem_rdata(mem_rdata), .rd_err(rd_err_i[1])
  );

  always #10 Clk50 = ~Clk50;

  function automatic logic [127:0] f(input logic [21:0] a);
    return {10'h155, a, 10'h2AA, ~a, 32'hC0DE_0000 | {10'd0, a}, 32'h1234_5678 ^ {10'd0, a}};
  endfunction

  // memory model: grant after gnt_dly cycles, data rv_dly cycles after grant
  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge Clk50);
      if (mem_req === 1'b1) begin
        ra = mem_addr;
        repeat (gnt_dly) @(negedge Clk50);
        mem_gnt = 1'b1;
        @(negedge Clk50);
        mem_gnt = 1'b0;
        repeat (rv_dly - 1) @(negedge Clk50);
        mem_rvalid = 1'b1;
        mem_rdata = f(ra);
        @(negedge Clk50);
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [21:0] addr);
    exp_q.push_back('{v: v, addr: addr});
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    exp_t e;
    cyc = 0;
    do begin
      @(negedge Clk50);
      cyc++;
    end while (!(a_ac || v_ac) && cyc < budget);
    chk("ack_seen", 128'(a_ac | v_ac), 128'(1'b1));
    chk("sb_nonempty", 128'(exp_q.size() != 0), 128'(1'b1));
    if (!(a_ac || v_ac) || exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("ack_port", 128'({a_ac, v_ac}), 128'(e.v ? 2'b01 : 2'b10));
    chk("ack_data", e.v ? v_data : a_data, f(e.addr));
    if (e.v) exp_v = f(e.addr);
    else exp_a = f(e.addr);
  endtask

  initial begin
    repeat (3) @(negedge Clk50);
    chk("rst_outs", 128'({mem_req, a_ac, v_ac, a_wait, v_wait, rd_err}), 128'(0));
    chk("rst_data", a_data | v_data, 128'(0));
    reset = 1'b0;
    @(negedge Clk50);
    // single audio read
    gnt_dly = 2;
    rv_dly = 3;
    a_addr = 22'h00010;
    a_rd = 1'b1;
    push(1'b0, 22'h00010);
    @(negedge Clk50);
    chk("t1_req", 128'({mem_req, v_wait, a_wait}), 128'(3'b110));
    chk("t1_addr", 128'(mem_addr), 128'(22'h00010));
    wait_ack(30, n);
    a_rd = 1'b0;
    chk("t1_latency", 128'(n), 128'(6));
    @(negedge Clk50);
    chk("t1_ac_pulse", 128'({a_ac, v_wait}), 128'(2'b01));
    repeat (6) @(negedge Clk50);
    chk("t1_data_held", a_data, f(22'h00010));
    chk("t1_idle", 128'({mem_req, v_wait, a_wait}), 128'(0));
    // simultaneous requests: audio first, video after the gap
    gnt_dly = 1;
    rv_dly = 2;
    a_addr = 22'h00020;
    v_addr = 22'h00300;
    a_rd = 1'b1;
    v_rd = 1'b1;
    push(1'b0, 22'h00020);
    push(1'b1, 22'h00300);
    wait_ack(30, n);
    a_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk50);
      chk("t2_v_held_off", 128'({v_wait, v_ac, mem_req}), 128'(3'b100));
    end
    @(negedge Clk50);
    chk("t2_idle", 128'({v_wait, a_wait, mem_req}), 128'(0));
    @(negedge Clk50);
    chk("t2_v_req", 128'({mem_req, a_wait, v_wait}), 128'(3'b110));
    chk("t2_v_addr", 128'(mem_addr), 128'(22'h00300));
    wait_ack(30, n);
    v_rd = 1'b0;
    repeat (8) @(negedge Clk50);
    // 200-word audio burst with one idle cycle between words, video pending
    gnt_dly = 0;
    rv_dly = 1;
    v_addr = 22'h3FFFFF;
    v_rd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a_addr = 22'h01000 + 22'(i);
      a_rd = 1'b1;
      push(1'b0, a_addr);
      wait_ack(30, n);
      a_rd = 1'b0;
      if (i < 199) repeat (2) @(negedge Clk50);
    end
    n = 0;
    do begin
      @(negedge Clk50);
      n++;
    end while (!mem_req && n < 20);
    chk("t3_v_req_delay", 128'(n), 128'(6));
    chk("t3_v_addr", 128'(mem_addr), 128'(22'h3FFFFF));
    push(1'b1, 22'h3FFFFF);
    wait_ack(30, n);
    v_rd = 1'b0;
    repeat (8) @(negedge Clk50);
    // spurious rvalid while idle
    spur = 1'b1;
    @(negedge Clk50);
    spur = 1'b0;
    @(negedge Clk50);
    chk("t5_no_ack", 128'({a_ac, v_ac, mem_req}), 128'(0));
    chk("t5_err", 128'(rd_err), 128'(1'b1));
    chk("t5_a_data", a_data, exp_a);
    chk("t5_v_data", v_data, exp_v);
    repeat (3) @(negedge Clk50);
    chk("t5_err_sticky", 128'(rd_err), 128'(1'b1));
    // reset during WAIT, then a late rvalid
    reset = 1'b1;
    #1;
    chk("t6_rst_clear", 128'({rd_err, mem_req}), 128'(0));
    chk("t6_rst_data", a_data | v_data, 128'(0));
    @(negedge Clk50);
    reset = 1'b0;
    gnt_dly = 1;
    rv_dly = 10;
    a_addr = 22'h0002A;
    a_rd = 1'b1;
    repeat (4) @(negedge Clk50);
    chk("t6_in_wait", 128'({mem_req, v_wait}), 128'(2'b01));
    reset = 1'b1;
    a_rd = 1'b0;
    #1;
    chk("t6_async", 128'({mem_req, a_wait, v_wait}), 128'(0));
    @(negedge Clk50);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk50);
      chk("t6_quiet", 128'({a_ac, v_ac, mem_req}), 128'(0));
    end
    chk("t6_late_err", 128'(rd_err), 128'(1'b1));
    chk("t6_data_kept", a_data, 128'(0));
    // lock limit of 4 words on the MAX_LOCK=4 build
    sel = 1'b1;
    reset = 1'b1;
    @(negedge Clk50);
    reset = 1'b0;
    gnt_dly = 0;
    rv_dly = 1;
    v_addr = 22'h00077;
    v_rd = 1'b1;
    a_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_addr = 22'h00500 + 22'(i);
      push(1'b0, a_addr);
      wait_ack(30, n);
    end
    a_addr = 22'h00504;
    @(negedge Clk50);
    chk("t4_released", 128'({mem_req, a_wait, v_wait}), 128'(0));
    @(negedge Clk50);
    chk("t4_audio_again", 128'({mem_req, v_wait}), 128'(2'b11));
    chk("t4_addr", 128'(mem_addr), 128'(22'h00504));
    push(1'b0, 22'h00504);
    wait_ack(30, n);
    a_rd = 1'b0;
    push(1'b1, 22'h00077);
    wait_ack(30, n);
    v_rd = 1'b0;
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
